// File: rtl/hs_pkg.sv
// ---------------------------------------------------------------------------
// hs_pkg
//   Shared types and limits for the multi-channel four-phase REQ/ACK
//   handshake initiator (hs_initiator_multi / hs_channel).
//
//   hs_state_t  : per-channel handshake FSM state encoding
//   HS_MAX_CH   : upper bound on the number of channels one instance supports
// ---------------------------------------------------------------------------
package hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_REQ     = 2'd1,
    HS_RELEASE = 2'd2
  } hs_state_t;

  localparam int HS_MAX_CH = 16;

endpackage : hs_pkg

// File: rtl/hs_channel.sv
// ---------------------------------------------------------------------------
// hs_channel
//   One four-phase REQ/ACK handshake initiator channel. Turns a rising edge on
//   the asynchronous send level into one complete req/ack transaction with an
//   external responder. Holds the input synchronisers, send edge detect, a
//   one-deep pending request, the handshake FSM, the completed-transfer
//   counter and the sticky error flag.
//
//   Optional build macro HS_TIMEOUT_EN: adds a per-channel timer that aborts a
//   transaction stuck in REQ or RELEASE for TIMEOUT_CYC cycles (err set, req
//   dropped, back to IDLE, pending kept, no done pulse).
//
//   Ports
//     clk         system clock
//     reset       synchronous, active-high reset
//     send        asynchronous request level; rising edge asks for a transfer
//     ack_in      asynchronous acknowledge from the responder
//     err_clr     one-cycle synchronous clear of err
//     req_out     registered request to the responder
//     busy        FSM not idle, or a request is pending
//     done_pulse  one-cycle pulse when a transfer completes
//     err         sticky error (overflow, spurious ack, timeout)
//     done_cnt    completed-transfer counter, wraps
//
//   State table
//     state      | meaning
//     HS_IDLE    | no transfer; req low; ack must stay low
//     HS_REQ     | req high, waiting for synchronised ack high
//     HS_RELEASE | req low, waiting for synchronised ack low to complete
// ---------------------------------------------------------------------------
module hs_channel
  import hs_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
`ifdef HS_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 1000,
`endif
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send,
  input  logic             ack_in,
  input  logic             err_clr,
  output logic             req_out,
  output logic             busy,
  output logic             done_pulse,
  output logic             err,
  output logic [CNT_W-1:0] done_cnt
);

  logic [SYNC_STAGES-1:0] send_sync;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   send_s;
  logic                   ack_s;
  logic                   send_d;
  logic                   send_edge;

  hs_state_t state;
  hs_state_t state_nxt;
  logic      pending;
  logic      pending_nxt;
  logic      err_nxt;
  logic      done_nxt;
  logic      timeout;

  // Input synchronisers plus the registered copy used for send edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      send_sync <= '0;
      ack_sync  <= '0;
      send_d    <= 1'b0;
    end else begin
      send_sync <= {send_sync[SYNC_STAGES-2:0], send};
      ack_sync  <= {ack_sync[SYNC_STAGES-2:0], ack_in};
      send_d    <= send_s;
    end
  end

  assign send_s    = send_sync[SYNC_STAGES-1];
  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign send_edge = send_s & ~send_d;

`ifdef HS_TIMEOUT_EN
  localparam int              TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] tmr;

  // Down-counter reloaded on every state change; loading TIMEOUT_CYC-1 on the
  // entry edge makes the abort edge land exactly TIMEOUT_CYC edges later.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr <= '0;
    end else if (state_nxt != state) begin
      tmr <= TMR_LOAD;
    end else if (tmr != '0) begin
      tmr <= tmr - TMR_W'(1);
    end
  end

  assign timeout = (state != HS_IDLE) && (tmr == '0);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    err_nxt     = err;
    done_nxt    = 1'b0;

    // Clear first so that any error condition below overrides it.
    if (err_clr) begin
      err_nxt = 1'b0;
    end

    case (state)
      HS_IDLE: begin
        if (ack_s) begin
          err_nxt = 1'b1;
        end
        if (send_edge || pending) begin
          state_nxt = HS_REQ;
          // A queued request is consumed here; a fresh edge arriving on the
          // same cycle takes its place in the queue.
          pending_nxt = pending & send_edge;
        end
      end

      HS_REQ: begin
        if (timeout) begin
          state_nxt = HS_IDLE;
          err_nxt   = 1'b1;
        end else if (ack_s) begin
          state_nxt = HS_RELEASE;
        end
      end

      HS_RELEASE: begin
        if (timeout) begin
          state_nxt = HS_IDLE;
          err_nxt   = 1'b1;
        end else if (!ack_s) begin
          state_nxt = HS_IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt = HS_IDLE;
      end
    endcase

    // Edges outside IDLE (including the RELEASE->IDLE cycle) are queued.
    if ((state != HS_IDLE) && send_edge) begin
      if (pending) begin
        err_nxt = 1'b1;
      end else begin
        pending_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HS_IDLE;
      pending    <= 1'b0;
      err        <= 1'b0;
      req_out    <= 1'b0;
      done_pulse <= 1'b0;
      done_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      err        <= err_nxt;
      req_out    <= (state_nxt == HS_REQ);
      done_pulse <= done_nxt;
      if (done_nxt) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (state != HS_IDLE) | pending;

endmodule : hs_channel

// File: rtl/hs_initiator_multi.sv
// ---------------------------------------------------------------------------
// hs_initiator_multi
//   N_CH independent four-phase REQ/ACK handshake initiators. Each bit of the
//   per-channel buses is served by its own hs_channel; channels never interact.
//
//   Optional build macro HS_TIMEOUT_EN: enables the per-channel REQ/RELEASE
//   timeout of TIMEOUT_CYC cycles. Without it TIMEOUT_CYC only takes part in
//   the configuration sanity check.
//
//   Parameters
//     N_CH         number of channels (1..HS_MAX_CH)
//     SYNC_STAGES  synchroniser depth on send and ack_in (>= 2)
//     CNT_W        width of each completed-transfer counter
//     TIMEOUT_CYC  REQ/RELEASE timeout in cycles (HS_TIMEOUT_EN only)
//
//   Ports
//     clk         system clock
//     reset       synchronous, active-high reset
//     send        [N_CH]  asynchronous send levels
//     ack_in      [N_CH]  asynchronous acknowledges
//     err_clr     [N_CH]  one-cycle error clears
//     req_out     [N_CH]  registered requests
//     busy        [N_CH]  channel busy
//     done_pulse  [N_CH]  transfer-complete pulses
//     err         [N_CH]  sticky error flags
//     done_cnt    [N_CH*CNT_W] counters; channel i at [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module hs_initiator_multi
  import hs_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       send,
  input  logic [N_CH-1:0]       ack_in,
  input  logic [N_CH-1:0]       err_clr,
  output logic [N_CH-1:0]       req_out,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done_pulse,
  output logic [N_CH-1:0]       err,
  output logic [N_CH*CNT_W-1:0] done_cnt
);

  // An unsupported configuration builds no channels and holds every output
  // low, which is obvious on first bring-up rather than silently misbehaving.
  localparam bit CFG_OK = (N_CH >= 1) && (N_CH <= HS_MAX_CH) &&
                          (SYNC_STAGES >= 2) && (CNT_W >= 1) &&
                          (TIMEOUT_CYC >= 1);

  if (CFG_OK) begin : g_cfg_ok
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      hs_channel #(
        .SYNC_STAGES (SYNC_STAGES),
`ifdef HS_TIMEOUT_EN
        .TIMEOUT_CYC (TIMEOUT_CYC),
`endif
        .CNT_W       (CNT_W)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .send       (send[i]),
        .ack_in     (ack_in[i]),
        .err_clr    (err_clr[i]),
        .req_out    (req_out[i]),
        .busy       (busy[i]),
        .done_pulse (done_pulse[i]),
        .err        (err[i]),
        .done_cnt   (done_cnt[i*CNT_W +: CNT_W])
      );
    end
  end else begin : g_cfg_bad
    assign req_out    = '0;
    assign busy       = '0;
    assign done_pulse = '0;
    assign err        = '0;
    assign done_cnt   = '0;
  end

endmodule : hs_initiator_multi

// File: tb/tb_hs_initiator_multi.sv
module tb_hs_initiator_multi;

  localparam int N_CH  = 4;
  localparam int SYNC  = 2;
  localparam int CNT_W = 2;
  localparam int TMO   = 20;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_CH-1:0]       send;
  logic [N_CH-1:0]       ack_in;
  logic [N_CH-1:0]       err_clr;
  logic [N_CH-1:0]       req_out;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       done_pulse;
  logic [N_CH-1:0]       err;
  logic [N_CH*CNT_W-1:0] done_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  hs_initiator_multi #(
    .N_CH        (N_CH),
    .SYNC_STAGES (SYNC),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .send       (send),
    .ack_in     (ack_in),
    .err_clr    (err_clr),
    .req_out    (req_out),
    .busy       (busy),
    .done_pulse (done_pulse),
    .err        (err),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Advance n active edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] cnt(input int ch);
    return done_cnt[ch*CNT_W +: CNT_W];
  endfunction

  task automatic run_xfer(input int ch);
    send[ch] = 1'b1;
    tick(3);
    send[ch]   = 1'b0;
    ack_in[ch] = 1'b1;
    tick(3);
    ack_in[ch] = 1'b0;
    tick(3);
  endtask

  logic [CNT_W-1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    reset   = 1'b1;
    send    = '0;
    ack_in  = '0;
    err_clr = '0;
    tick(3);
    chk("rst_req",  32'(req_out),    32'h0);
    chk("rst_busy", 32'(busy),       32'h0);
    chk("rst_err",  32'(err),        32'h0);
    chk("rst_done", 32'(done_pulse), 32'h0);
    chk("rst_cnt",  32'(done_cnt),   32'h0);
    reset = 1'b0;
    tick(2);

    // Basic transfer on channel 0.
    send[0] = 1'b1;
    tick(2);
    chk("t1_req_early", 32'(req_out[0]), 32'd0);
    tick(1);
    chk("t1_req_rise",  32'(req_out[0]), 32'd1);
    chk("t1_busy",      32'(busy[0]),    32'd1);
    send[0] = 1'b0;
    tick(4);
    ack_in[0] = 1'b1;
    tick(2);
    chk("t1_req_hold",  32'(req_out[0]), 32'd1);
    tick(1);
    chk("t1_req_drop",  32'(req_out[0]), 32'd0);
    chk("t1_busy_rel",  32'(busy[0]),    32'd1);
    ack_in[0] = 1'b0;
    tick(2);
    chk("t1_done_early", 32'(done_pulse[0]), 32'd0);
    tick(1);
    chk("t1_done",      32'(done_pulse[0]), 32'd1);
    chk("t1_cnt",       32'(cnt(0)),        32'd1);
    chk("t1_busy_end",  32'(busy[0]),       32'd0);
    tick(1);
    chk("t1_done_1cyc", 32'(done_pulse[0]), 32'd0);

    // Pending and overflow on channel 1.
    send[1] = 1'b1;
    tick(3);
    chk("t2_req", 32'(req_out[1]), 32'd1);
    send[1] = 1'b0;
    tick(3);
    send[1] = 1'b1;
    tick(3);
    chk("t2_pend_noerr", 32'(err[1]), 32'd0);
    send[1] = 1'b0;
    tick(3);
    send[1] = 1'b1;
    tick(2);
    chk("t2_ovf_early", 32'(err[1]), 32'd0);
    tick(1);
    chk("t2_ovf", 32'(err[1]), 32'd1);
    send[1] = 1'b0;
    ack_in[1] = 1'b1;
    tick(3);
    chk("t2_req_drop", 32'(req_out[1]), 32'd0);
    ack_in[1] = 1'b0;
    tick(3);
    chk("t2_done1", 32'(done_pulse[1]), 32'd1);
    chk("t2_cnt1",  32'(cnt(1)),        32'd1);
    chk("t2_busy_pend", 32'(busy[1]),   32'd1);
    tick(1);
    chk("t2_req2", 32'(req_out[1]), 32'd1);
    ack_in[1] = 1'b1;
    tick(3);
    ack_in[1] = 1'b0;
    tick(3);
    chk("t2_cnt2", 32'(cnt(1)),  32'd2);
    chk("t2_idle", 32'(busy[1]), 32'd0);
    tick(5);
    chk("t2_no_third_cnt", 32'(cnt(1)),     32'd2);
    chk("t2_no_third_req", 32'(req_out[1]), 32'd0);
    chk("t2_err_sticky",   32'(err[1]),     32'd1);
    err_clr[1] = 1'b1;
    tick(1);
    err_clr[1] = 1'b0;
    chk("t2_err_clr", 32'(err[1]), 32'd0);

    // Counter wrap on channel 2 (CNT_W = 2).
    for (int k = 0; k < 5; k++) begin
      run_xfer(2);
      chk($sformatf("t3_wrap%0d", k), 32'(cnt(2)), 32'(wrap_exp[k]));
    end
    chk("t3_cnt_ch0_untouched", 32'(cnt(0)), 32'd1);

    // Spurious ack on idle channel 3.
    ack_in[3] = 1'b1;
    tick(2);
    chk("t4_err_early", 32'(err[3]), 32'd0);
    tick(1);
    chk("t4_err",       32'(err[3]),     32'd1);
    chk("t4_req_low",   32'(req_out[3]), 32'd0);
    chk("t4_busy_low",  32'(busy[3]),    32'd0);
    chk("t4_other_err", 32'(err[2:0]),   32'd0);
    err_clr[3] = 1'b1;
    tick(1);
    err_clr[3] = 1'b0;
    chk("t4_set_wins", 32'(err[3]), 32'd1);
    ack_in[3] = 1'b0;
    tick(3);
    err_clr[3] = 1'b1;
    tick(1);
    err_clr[3] = 1'b0;
    chk("t4_clr", 32'(err[3]), 32'd0);

    // Reset while channel 0 is in REQ.
    send[0] = 1'b1;
    tick(3);
    chk("t5_req", 32'(req_out[0]), 32'd1);
    reset   = 1'b1;
    send[0] = 1'b0;
    tick(1);
    chk("t5_req",   32'(req_out[0]),    32'd0);
    chk("t5_busy",  32'(busy[0]),       32'd0);
    chk("t5_cnt0",  32'(cnt(0)),        32'd0);
    chk("t5_done",  32'(done_pulse[0]), 32'd0);
    chk("t5_cnt_all", 32'(done_cnt),    32'd0);
    tick(2);
    reset = 1'b0;
    tick(3);

    // Responder on channel 2 never acknowledges.
    send[2] = 1'b1;
    tick(3);
    chk("t6_req", 32'(req_out[2]), 32'd1);
    send[2] = 1'b0;
`ifdef HS_TIMEOUT_EN
    tick(TMO - 1);
    chk("t6_tmo_early_req", 32'(req_out[2]), 32'd1);
    chk("t6_tmo_early_err", 32'(err[2]),     32'd0);
    tick(1);
    chk("t6_tmo_req",  32'(req_out[2]),    32'd0);
    chk("t6_tmo_err",  32'(err[2]),        32'd1);
    chk("t6_tmo_done", 32'(done_pulse[2]), 32'd0);
    chk("t6_tmo_cnt",  32'(cnt(2)),        32'd0);
`else
    tick(1000);
    chk("t6_hold_req",  32'(req_out[2]), 32'd1);
    chk("t6_hold_err",  32'(err[2]),     32'd0);
    chk("t6_hold_busy", 32'(busy[2]),    32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_hs_initiator_multi

// File: doc/hs_initiator_multi.md
Name: hs_initiator_multi

Overview:
- Parametrised, multi-channel four-phase REQ/ACK handshake initiator.
- Successor to the single-channel device-A handshake FSM.
- Each channel turns a user "send" level into a full req/ack transaction with an external responder.
- Per channel: synchronises the asynchronous inputs, queues one pending request, counts completed transfers and flags protocol errors. Sits between the board-level input synchronisers/LEDs and the external responder devices.

Parameters:
- N_CH, 4, number of independent handshake channels (1..16).
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on send and ack_in (>=2).
- CNT_W, 8, width of each per-channel completed-transfer counter.
- TIMEOUT_CYC, 1000, max cycles in REQ or RELEASE before error (used only with HS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- send  in  N_CH  asynchronous level per channel; a rising edge requests one transfer
- ack_in  in  N_CH  asynchronous acknowledge from each responder
- err_clr  in  N_CH  synchronous, one-cycle clear of the matching err bit
- req_out  out  N_CH  registered request to each responder
- busy  out  N_CH  channel not in IDLE, or request pending
- done_pulse  out  N_CH  one-cycle pulse when a transfer completes (ack observed low after release)
- err  out  N_CH  sticky error flag
- done_cnt  out  N_CH*CNT_W  completed-transfer counters; channel i at bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset: synchronous, active-high. All synchroniser flops, req_out, busy, done_pulse, err, done_cnt and the pending flag go to 0; every FSM enters IDLE. Reset mid-transfer drops req_out on the next edge; no done_pulse is issued.
- Synchronisation: send and ack_in each pass through SYNC_STAGES flops. A send rising edge is detected against a registered copy of the synchronised value.
- Per-channel FSM states: IDLE, REQ, RELEASE.
  - IDLE -> REQ on a send edge or pending=1. req_out=1 registered, so req_out rises SYNC_STAGES+1 edges after the first edge sampling send high. Pending is cleared on entry.
  - REQ: hold req_out=1 until synchronised ack=1, then go to RELEASE with req_out=0.
  - RELEASE: wait for synchronised ack=0, then go to IDLE. On the same edge: done_pulse=1 for one cycle; done_cnt increments, wrapping 2^CNT_W-1 -> 0.
- Pending queue (one deep): a send edge outside IDLE sets pending.
  - A send edge while pending is already 1 sets err (overflow); pending stays 1.
  - Send edge arriving on the same cycle that RELEASE->IDLE happens: it becomes pending and starts the next transfer on the following cycle.
- Protocol error: synchronised ack=1 while in IDLE sets err. The FSM stays in IDLE.
- err_clr: clears err on the next edge. If err_clr and an error condition occur in the same cycle, set wins.
- Channel independence: channels never interact; simultaneous events on several channels are handled in parallel.
- busy = (state != IDLE) | pending.

Optional Feature:
- Macro: HS_TIMEOUT_EN.
- Defined:
  - A per-channel counter of width clog2(TIMEOUT_CYC+1) resets on every state change.
  - If it reaches TIMEOUT_CYC in REQ or RELEASE: err=1, req_out=0, go to IDLE, no done_pulse, pending retained.
- Undefined: no counter is built; a channel can wait in REQ/RELEASE forever.

Decomposition:
- Package hs_pkg: typedef enum logic [1:0] hs_state_t {HS_IDLE, HS_REQ, HS_RELEASE}; localparam HS_MAX_CH=16.
- One sub-module, hs_channel, holds for a single channel:
  - synchronisers;
  - edge detect;
  - pending flag;
  - FSM;
  - counter;
  - optional timeout.
- Top level hs_initiator_multi instantiates N_CH copies of hs_channel in a generate loop and concatenates the outputs.

Test Plan:
- Basic transfer: reset, then send[0] rises at cycle 10 with SYNC_STAGES=2 -> req_out[0]=1 at cycle 13. Responder raises ack 5 cycles later -> req_out drops 3 cycles after that. Ack falls -> done_pulse[0] one cycle, done_cnt[0]=1, busy[0]=0.
- Pending and overflow: three send edges on channel 1 during one transfer -> exactly two transfers total (done_cnt[1]=2), err[1]=1. err_clr[1] pulse -> err[1]=0 on the next cycle.
- Counter wrap: CNT_W=2, run 5 transfers on channel 2 -> done_cnt[2] sequence 1,2,3,0,1.
- Spurious ack: ack_in[3]=1 while channel 3 idle -> err[3]=1 after SYNC_STAGES+1 cycles; req_out[3] stays 0; other channels unaffected.
- Reset mid-transfer: assert reset while channel 0 is in REQ -> next edge req_out[0]=0, busy[0]=0, done_cnt[0]=0, no done_pulse.
- HS_TIMEOUT_EN with TIMEOUT_CYC=20: responder never acks -> req_out drops and err=1 exactly 20 cycles after REQ entry. Without the macro: req_out still 1 after 1000 cycles.
